adv_timer_cmd_ctrl: RTL and testbench
=====================================

Name: adv_timer_cmd_ctrl

Overview:
Command sequencer for one advanced-timer channel. It sits between the APB register file and the timer's input stage and counter. It turns one-cycle software command pulses (start, stop, update, reset, arm) into the ctrl_active/ctrl_update/ctrl_arm/ctrl_rst controls. It also holds the shadow copy of the input-stage configuration and applies it glitch-free: immediately when idle, at counter end when running.

Parameters:
SEL_W, 8, width of input-select field (matches input-stage cfg_sel)
MODE_W, 3, width of trigger-mode field

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
cmd_start_i  in  1  start pulse from register file
cmd_stop_i  in  1  stop pulse
cmd_update_i  in  1  update-config pulse
cmd_reset_i  in  1  counter reset pulse
cmd_arm_i  in  1  arm pulse
cnt_end_i  in  1  counter end-of-period strobe
cfg_sel_i  in  SEL_W  software input select
cfg_mode_i  in  MODE_W  software trigger mode
cfg_sel_clk_i  in  1  software low-speed-clock qualify
ctrl_active_o  out  1  channel running
ctrl_update_o  out  1  one-cycle update strobe to input stage/counter
ctrl_arm_o  out  1  one-cycle arm strobe
ctrl_rst_o  out  1  one-cycle counter reset strobe
cfg_sel_o  out  SEL_W  applied input select
cfg_mode_o  out  MODE_W  applied trigger mode
cfg_sel_clk_o  out  1  applied clock qualify
upd_pending_o  out  1  update staged, waiting for cnt_end_i

Behaviour:
- Reset: all outputs 0; FSM in IDLE; staged config 0; pending 0.
- FSM states: IDLE and RUN. ctrl_active_o = (state==RUN), registered.
- Same-cycle command priority: reset > stop > start. update and arm are evaluated independently of this chain.
- IDLE -> RUN on cmd_start_i with no cmd_stop_i. ctrl_active_o is high from the next cycle.
- RUN -> IDLE on cmd_stop_i.
- cmd_start_i while in RUN: ignored.
- cmd_stop_i while in IDLE: ignored.
- cmd_reset_i: ctrl_rst_o high in cycle N+1. Clears pending. FSM state unchanged. A stop in the same cycle is still executed.
- cmd_update_i in cycle N: cfg_sel_i, cfg_mode_i and cfg_sel_clk_i are captured into the staged register at edge N.
  - IDLE: apply at edge N+1. cfg_*_o are new from N+2; ctrl_update_o is high in cycle N+2. The strobe never precedes valid config.
  - RUN: set pending; upd_pending_o is high from N+1. The first cnt_end_i in cycle M (M>N) applies: cfg_*_o new and ctrl_update_o high in M+2 (same 2-cycle shape as IDLE). Pending clears at M+1.
- A new cmd_update_i while pending overwrites the staged values; the last write wins. Only one ctrl_update_o is issued.
- cmd_stop_i while pending: the pending update is applied as in IDLE, counted from the stop cycle.
- cmd_reset_i with pending: pending is discarded. Staged values are kept but not applied.
- cnt_end_i in the same cycle as cmd_update_i in RUN: does not apply. It waits for the next cnt_end_i.
- cmd_arm_i in cycle N: ctrl_arm_o high in N+1, in both states.
- ctrl_update_o, ctrl_arm_o and ctrl_rst_o are each exactly one cycle wide per accepted command.
- Back-to-back commands on consecutive cycles are each honoured.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
Macro ADV_TIMER_CMD_ERR_EN.
- Defined:
  - Adds output port err_o (1 bit), reset 0.
  - err_o is a sticky flag, set when cmd_update_i arrives while upd_pending_o=1 (overwrite) or cmd_start_i arrives in RUN.
  - Cleared by cmd_reset_i; set takes priority in the same cycle.
- Undefined: err_o absent; behaviour otherwise identical.

Test Plan:
- Reset release, no commands for 10 cycles -> all outputs 0, FSM IDLE.
- IDLE, cfg_sel_i=5, cfg_mode_i=3, cmd_update_i at cycle 0 -> cfg_sel_o=5 and cfg_mode_o=3 from cycle 2; ctrl_update_o high only in cycle 2.
- cmd_start_i at 0; cmd_update_i (sel=7) at 3; cnt_end_i at 10 -> upd_pending_o high cycles 4..10; ctrl_update_o high cycle 12; cfg_sel_o=7 from 12.
- RUN with pending; cmd_update_i sel=2 then sel=9 before cnt_end_i -> single ctrl_update_o, cfg_sel_o=9; with ADV_TIMER_CMD_ERR_EN, err_o=1.
- cmd_reset_i, cmd_stop_i and cmd_start_i all in the same cycle, in RUN -> ctrl_rst_o one pulse, ctrl_active_o low next cycle, pending cleared.
- cmd_arm_i at cycles 4 and 5 -> ctrl_arm_o high at 5 and 6; cnt_end_i concurrent with cmd_update_i in RUN -> no apply until next cnt_end_i.

Source files
------------

// File: rtl/adv_timer_cmd_ctrl.sv
// Command sequencer for one advanced-timer channel: turns command pulses into timer controls and stages/applies input-stage config.
// Optional macro ADV_TIMER_CMD_ERR_EN adds a sticky err_o flag (update overwrite or start while running).
module adv_timer_cmd_ctrl #(
  parameter int SEL_W  = 8,
  parameter int MODE_W = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_start_i,
  input  logic              cmd_stop_i,
  input  logic              cmd_update_i,
  input  logic              cmd_reset_i,
  input  logic              cmd_arm_i,
  input  logic              cnt_end_i,
  input  logic [SEL_W-1:0]  cfg_sel_i,
  input  logic [MODE_W-1:0] cfg_mode_i,
  input  logic              cfg_sel_clk_i,
  output logic              ctrl_active_o,
  output logic              ctrl_update_o,
  output logic              ctrl_arm_o,
  output logic              ctrl_rst_o,
  output logic [SEL_W-1:0]  cfg_sel_o,
  output logic [MODE_W-1:0] cfg_mode_o,
  output logic              cfg_sel_clk_o,
  output logic              upd_pending_o
`ifdef ADV_TIMER_CMD_ERR_EN
  ,
  output logic              err_o
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pending;
  logic              r_apply;
  logic              r_update;
  logic              r_arm;
  logic              r_rst;
  logic [SEL_W-1:0]  r_sel_stg;
  logic [MODE_W-1:0] r_mode_stg;
  logic              r_clk_stg;
  logic [SEL_W-1:0]  r_sel;
  logic [MODE_W-1:0] r_mode;
  logic              r_sel_clk;

  logic w_stop_run;
  logic w_upd_now;
  logic w_upd_defer;
  logic w_pend_fire;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Reset never changes state; stop outranks start.
  always_comb begin
    w_state_nxt = r_state;
    w_stop_run  = 1'b0;
    case (r_state)
      ST_IDLE: if (cmd_start_i && !cmd_stop_i) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (cmd_stop_i) begin
          w_state_nxt = ST_IDLE;
          w_stop_run  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A stop makes an update behave as in idle. A cnt_end coinciding with an update never fires.
  assign w_upd_now   = cmd_update_i && ((r_state == ST_IDLE) || w_stop_run);
  assign w_upd_defer = cmd_update_i && (r_state == ST_RUN) && !cmd_stop_i;
  assign w_pend_fire = r_pending && !cmd_reset_i &&
                       ((cnt_end_i && !cmd_update_i) || w_stop_run);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pending  <= 1'b0;
      r_apply    <= 1'b0;
      r_update   <= 1'b0;
      r_arm      <= 1'b0;
      r_rst      <= 1'b0;
      r_sel_stg  <= '0;
      r_mode_stg <= '0;
      r_clk_stg  <= 1'b0;
      r_sel      <= '0;
      r_mode     <= '0;
      r_sel_clk  <= 1'b0;
    end else begin
      r_arm    <= cmd_arm_i;
      r_rst    <= cmd_reset_i;
      r_apply  <= w_upd_now || w_pend_fire;
      r_update <= r_apply;
      if (cmd_update_i) begin
        r_sel_stg  <= cfg_sel_i;
        r_mode_stg <= cfg_mode_i;
        r_clk_stg  <= cfg_sel_clk_i;
      end
      if (cmd_reset_i || w_pend_fire) r_pending <= 1'b0;
      else if (w_upd_defer)           r_pending <= 1'b1;
      // Config lands together with the strobe, so the strobe never leads valid data.
      if (r_apply) begin
        r_sel     <= r_sel_stg;
        r_mode    <= r_mode_stg;
        r_sel_clk <= r_clk_stg;
      end
    end
  end

`ifdef ADV_TIMER_CMD_ERR_EN
  logic r_err;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_err <= 1'b0;
    else if ((cmd_update_i && r_pending) || (cmd_start_i && r_state == ST_RUN)) r_err <= 1'b1;
    else if (cmd_reset_i) r_err <= 1'b0;
  end
  assign err_o = r_err;
`endif

  assign ctrl_active_o = (r_state == ST_RUN);
  assign ctrl_update_o = r_update;
  assign ctrl_arm_o    = r_arm;
  assign ctrl_rst_o    = r_rst;
  assign cfg_sel_o     = r_sel;
  assign cfg_mode_o    = r_mode;
  assign cfg_sel_clk_o = r_sel_clk;
  assign upd_pending_o = r_pending;

endmodule

// File: tb/tb_adv_timer_cmd_ctrl.sv
// Directed bench for adv_timer_cmd_ctrl; a monitor also checks the config delivered with every update strobe.
module tb_adv_timer_cmd_ctrl;
  localparam int SEL_W  = 8;
  localparam int MODE_W = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_start, cmd_stop, cmd_update, cmd_reset, cmd_arm, cnt_end;
  logic [SEL_W-1:0]  cfg_sel;
  logic [MODE_W-1:0] cfg_mode;
  logic              cfg_sel_clk;
  logic              ctrl_active, ctrl_update, ctrl_arm, ctrl_rst;
  logic [SEL_W-1:0]  cfg_sel_q;
  logic [MODE_W-1:0] cfg_mode_q;
  logic              cfg_sel_clk_q;
  logic              upd_pending;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  logic [SEL_W-1:0] exp_q[$];

  adv_timer_cmd_ctrl #(.SEL_W(SEL_W), .MODE_W(MODE_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_update_i(cmd_update),
    .cmd_reset_i(cmd_reset), .cmd_arm_i(cmd_arm), .cnt_end_i(cnt_end),
    .cfg_sel_i(cfg_sel), .cfg_mode_i(cfg_mode), .cfg_sel_clk_i(cfg_sel_clk),
    .ctrl_active_o(ctrl_active), .ctrl_update_o(ctrl_update),
    .ctrl_arm_o(ctrl_arm), .ctrl_rst_o(ctrl_rst),
    .cfg_sel_o(cfg_sel_q), .cfg_mode_o(cfg_mode_q), .cfg_sel_clk_o(cfg_sel_clk_q),
    .upd_pending_o(upd_pending)
`ifdef ADV_TIMER_CMD_ERR_EN
    , .err_o(err)
`endif
  );
`ifndef ADV_TIMER_CMD_ERR_EN
  assign err = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are observed 1ns after the edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cmds();
    cmd_start = 0; cmd_stop = 0; cmd_update = 0; cmd_reset = 0; cmd_arm = 0; cnt_end = 0;
  endtask

  task automatic set_cfg(input logic [SEL_W-1:0] s, input logic [MODE_W-1:0] m, input logic c);
    cfg_sel = s; cfg_mode = m; cfg_sel_clk = c;
  endtask

  // scoreboard: every update strobe must carry the next expected select value
  always @(negedge clk) begin
    if (rstn && ctrl_update) begin
      if (exp_q.size() == 0) check("unexpected_update", 32'(ctrl_update), 32'd0);
      else                   check("update_sel", 32'(cfg_sel_q), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    idle_cmds();
    set_cfg('0, '0, 1'b0);
    rstn = 0;
    cyc(3);
    rstn = 1;

    // reset state, 10 quiet cycles
    cyc(10);
    check("rst_active", 32'(ctrl_active), 0);
    check("rst_update", 32'(ctrl_update), 0);
    check("rst_arm", 32'(ctrl_arm), 0);
    check("rst_rst", 32'(ctrl_rst), 0);
    check("rst_sel", 32'(cfg_sel_q), 0);
    check("rst_mode", 32'(cfg_mode_q), 0);
    check("rst_selclk", 32'(cfg_sel_clk_q), 0);
    check("rst_pending", 32'(upd_pending), 0);
    check("rst_err", 32'(err), 0);

    // idle update: sel=5 mode=3, visible with strobe two cycles later
    set_cfg(8'd5, 3'd3, 1'b1); cmd_update = 1; exp_q.push_back(8'd5);
    cyc();  idle_cmds(); set_cfg(8'hEE, 3'd7, 1'b0);
    check("idle_c1_update", 32'(ctrl_update), 0);
    check("idle_c1_sel", 32'(cfg_sel_q), 0);
    cyc();
    check("idle_c2_update", 32'(ctrl_update), 1);
    check("idle_c2_sel", 32'(cfg_sel_q), 5);
    check("idle_c2_mode", 32'(cfg_mode_q), 3);
    check("idle_c2_selclk", 32'(cfg_sel_clk_q), 1);
    cyc();
    check("idle_c3_update", 32'(ctrl_update), 0);
    check("idle_c3_sel", 32'(cfg_sel_q), 5);

    // stop while idle ignored; start+stop together in idle does not start
    cmd_stop = 1; cyc(); idle_cmds();
    check("idle_stop_ignored", 32'(ctrl_active), 0);
    cmd_start = 1; cmd_stop = 1; cyc(); idle_cmds();
    check("start_stop_idle", 32'(ctrl_active), 0);

    // start at 0, update sel=7 at 3, cnt_end at 10
    cmd_start = 1; cyc(); idle_cmds();
    check("run_active", 32'(ctrl_active), 1);
    cyc(2);
    set_cfg(8'd7, 3'd1, 1'b0); cmd_update = 1; exp_q.push_back(8'd7);
    cyc(); idle_cmds();
    check("run_c4_pending", 32'(upd_pending), 1);
    check("run_c4_sel", 32'(cfg_sel_q), 5);
    cyc(6);
    check("run_c10_pending", 32'(upd_pending), 1);
    check("run_c10_update", 32'(ctrl_update), 0);
    cnt_end = 1; cyc(); idle_cmds();
    check("run_c11_pending", 32'(upd_pending), 0);
    check("run_c11_update", 32'(ctrl_update), 0);
    check("run_c11_sel", 32'(cfg_sel_q), 5);
    cyc();
    check("run_c12_update", 32'(ctrl_update), 1);
    check("run_c12_sel", 32'(cfg_sel_q), 7);
    check("run_c12_mode", 32'(cfg_mode_q), 1);
    cyc();
    check("run_c13_update", 32'(ctrl_update), 0);

    // start while running is ignored
    cmd_start = 1; cyc(); idle_cmds();
    check("run_start_ignored", 32'(ctrl_active), 1);
`ifdef ADV_TIMER_CMD_ERR_EN
    check("err_start_run", 32'(err), 1);
    cmd_reset = 1; cyc(); idle_cmds();
    check("err_cleared", 32'(err), 0);
`endif

    // overwrite while pending: sel=2 then sel=9, single strobe carrying 9
    set_cfg(8'd2, 3'd2, 1'b0); cmd_update = 1; cyc();
    set_cfg(8'd9, 3'd4, 1'b1); cyc(); idle_cmds();
    cyc(2);
    check("ovw_pending", 32'(upd_pending), 1);
    check("ovw_sel_held", 32'(cfg_sel_q), 7);
`ifdef ADV_TIMER_CMD_ERR_EN
    check("ovw_err", 32'(err), 1);
`endif
    cnt_end = 1; exp_q.push_back(8'd9); cyc(); idle_cmds();
    cyc();
    check("ovw_update", 32'(ctrl_update), 1);
    check("ovw_sel", 32'(cfg_sel_q), 9);
    check("ovw_selclk", 32'(cfg_sel_clk_q), 1);
    cyc(3);

    // cnt_end concurrent with update does not apply
    set_cfg(8'h33, 3'd5, 1'b0); cmd_update = 1; cnt_end = 1; cyc(); idle_cmds();
    check("conc_pending", 32'(upd_pending), 1);
    cyc();
    check("conc_no_update", 32'(ctrl_update), 0);
    check("conc_sel_held", 32'(cfg_sel_q), 9);
    cnt_end = 1; exp_q.push_back(8'h33); cyc(); idle_cmds();
    check("conc_pending_clr", 32'(upd_pending), 0);
    cyc();
    check("conc_update", 32'(ctrl_update), 1);
    check("conc_sel", 32'(cfg_sel_q), 8'h33);

    // arm on consecutive cycles
    cmd_arm = 1; cyc();
    check("arm_1", 32'(ctrl_arm), 1);
    cyc(); cmd_arm = 0;
    check("arm_2", 32'(ctrl_arm), 1);
    cyc();
    check("arm_off", 32'(ctrl_arm), 0);

    // reset+stop+start together while running with a pending update
    set_cfg(8'h44, 3'd6, 1'b1); cmd_update = 1; cyc(); idle_cmds();
    check("rss_pending_set", 32'(upd_pending), 1);
    cmd_reset = 1; cmd_stop = 1; cmd_start = 1; cyc(); idle_cmds();
    check("rss_rst", 32'(ctrl_rst), 1);
    check("rss_active", 32'(ctrl_active), 0);
    check("rss_pending", 32'(upd_pending), 0);
    cyc();
    check("rss_rst_off", 32'(ctrl_rst), 0);
    check("rss_no_update", 32'(ctrl_update), 0);
    cyc();
    check("rss_sel_kept", 32'(cfg_sel_q), 8'h33);

    // stop while pending applies as in idle, counted from the stop
    cmd_start = 1; cyc(); idle_cmds();
    set_cfg(8'h55, 3'd2, 1'b0); cmd_update = 1; exp_q.push_back(8'h55); cyc(); idle_cmds();
    check("stp_pending", 32'(upd_pending), 1);
    cmd_stop = 1; cyc(); idle_cmds();
    check("stp_active", 32'(ctrl_active), 0);
    check("stp_pending_clr", 32'(upd_pending), 0);
    check("stp_c1_update", 32'(ctrl_update), 0);
    cyc();
    check("stp_c2_update", 32'(ctrl_update), 1);
    check("stp_c2_sel", 32'(cfg_sel_q), 8'h55);
    cyc(3);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
